// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// =============================================================================
// mem_access_stage_pkg : FSM state encoding and width defaults for the MEM stage
// Rev 1.0
// =============================================================================
package mem_access_stage_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int CNT_W          = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// =============================================================================
// mem_access_stage_if : req/ack data-memory bus between the MEM stage and memory
// Rev 1.0
// =============================================================================
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface
`default_nettype wire

// File: rtl/mem_access_stage_mem_wb_reg.sv
`default_nettype none
// =============================================================================
// mem_access_stage_mem_wb_reg : MEM/WB pipeline register; valid pulses on load
// Rev 1.0
// =============================================================================
module mem_access_stage_mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  reg_write_d,
  input  logic [REG_ADDR_W-1:0] dst_d,
  input  logic [DATA_W-1:0]     data_d,
  output logic                  valid,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] dst,
  output logic [DATA_W-1:0]     data
);

  // Payload holds between loads; only valid drops back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      reg_write <= 1'b0;
      dst       <= '0;
      data      <= '0;
    end else begin
      valid <= load;
      if (load) begin
        reg_write <= reg_write_d;
        dst       <= dst_d;
        data      <= data_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// =============================================================================
// mem_access_stage : MEM pipeline stage - branch resolve, req/ack load/store, MEM/WB
// Rev 1.0
// =============================================================================
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     adder_result,
  input  logic                  zero,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] dst_reg,
  input  logic                  ctl_branch,
  input  logic                  ctl_mem_read,
  input  logic                  ctl_mem_write,
  input  logic                  ctl_reg_write,
  input  logic                  ctl_mem_to_reg,
  output logic                  stall,
  output logic                  pc_src,
  output logic [DATA_W-1:0]     branch_target,
  mem_access_stage_if.master    mem,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  mem_err
);

  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_pc_src;
  logic [DATA_W-1:0]     r_branch_target;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [DATA_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_mem_err;
  logic [REG_ADDR_W-1:0] r_dst;
  logic                  r_reg_write;
  logic                  r_mem_to_reg;

  logic                  w_mem_op;
  logic                  w_timeout;
  logic                  w_wb_load;
  logic                  w_wb_reg_write;
  logic [REG_ADDR_W-1:0] w_wb_dst;
  logic [DATA_W-1:0]     w_wb_data;

  assign w_mem_op  = ctl_mem_read | ctl_mem_write;
  assign w_timeout = (r_state == ST_ACCESS) && !mem.ack && (r_cnt == c_timeout_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_pc_src        <= 1'b0;
      r_branch_target <= '0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_err       <= 1'b0;
      r_dst           <= '0;
      r_reg_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
    end else begin
      r_pc_src <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (ex_valid) begin
            r_branch_target <= adder_result;
            if (w_mem_op) begin
              r_state      <= ST_ACCESS;
              r_cnt        <= '0;
              r_mem_req    <= 1'b1;
              r_mem_we     <= ctl_mem_write;
              r_mem_addr   <= alu_result;
              r_mem_wdata  <= store_data;
              r_dst        <= dst_reg;
              // Any write (including read+write) never updates the register file.
              r_reg_write  <= ctl_reg_write & ~ctl_mem_write;
              r_mem_to_reg <= ctl_mem_to_reg;
            end else begin
              r_pc_src <= ctl_branch & zero;
            end
          end
        end
        ST_ACCESS: begin
          if (mem.ack || w_timeout) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (w_timeout) begin
              r_mem_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wb_load      = 1'b0;
    w_wb_reg_write = ctl_reg_write;
    w_wb_dst       = dst_reg;
    w_wb_data      = alu_result;
    unique case (r_state)
      ST_IDLE: begin
        w_wb_load = ex_valid & ~w_mem_op;
      end
      ST_ACCESS: begin
        w_wb_dst = r_dst;
        if (mem.ack) begin
          w_wb_load      = 1'b1;
          w_wb_reg_write = r_reg_write;
          w_wb_data      = r_mem_to_reg ? mem.rdata : r_mem_addr;
        end else if (w_timeout) begin
          w_wb_load      = 1'b1;
          w_wb_reg_write = 1'b0;
          w_wb_data      = '0;
        end
      end
      default: w_wb_load = 1'b0;
    endcase
  end

  mem_access_stage_mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (w_wb_load),
    .reg_write_d (w_wb_reg_write),
    .dst_d       (w_wb_dst),
    .data_d      (w_wb_data),
    .valid       (wb_valid),
    .reg_write   (wb_reg_write),
    .dst         (wb_dst),
    .data        (wb_data)
  );

  assign stall         = (r_state == ST_ACCESS);
  assign pc_src        = r_pc_src;
  assign branch_target = r_branch_target;
  assign mem_err       = r_mem_err;
  assign mem.req       = r_mem_req;
  assign mem.we        = r_mem_we;
  assign mem.addr      = r_mem_addr;
  assign mem.wdata     = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// =============================================================================
// tb_mem_access_stage : transaction-level model bench with random and directed traffic
// Rev 1.0
// =============================================================================
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, zero, ctl_branch, ctl_mem_read, ctl_mem_write;
  logic          ctl_reg_write, ctl_mem_to_reg;
  logic [DW-1:0] alu_result, adder_result, store_data;
  logic [RW-1:0] dst_reg;
  logic          stall, pc_src, wb_valid, wb_reg_write, mem_err;
  logic [DW-1:0] branch_target, wb_data;
  logic [RW-1:0] wb_dst;

  always #5 clk = ~clk;

  mem_access_stage_if #(.DATA_W(DW)) mem_bus ();

  mem_access_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
    .adder_result(adder_result), .zero(zero), .store_data(store_data),
    .dst_reg(dst_reg), .ctl_branch(ctl_branch), .ctl_mem_read(ctl_mem_read),
    .ctl_mem_write(ctl_mem_write), .ctl_reg_write(ctl_reg_write),
    .ctl_mem_to_reg(ctl_mem_to_reg), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .mem(mem_bus), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  typedef struct {
    logic          stall, pc_src, mem_req, mem_we, wb_valid, wb_reg_write, mem_err;
    logic [DW-1:0] branch_target, mem_addr, mem_wdata, wb_data;
    logic [RW-1:0] wb_dst;
  } exp_t;

  exp_t m;        // what the outputs should be after the most recent edge
  exp_t exp_cur;
  bit   exp_on = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  function automatic exp_t zero_rec();
    exp_t e;
    e.stall = 0; e.pc_src = 0; e.mem_req = 0; e.mem_we = 0; e.wb_valid = 0;
    e.wb_reg_write = 0; e.mem_err = 0; e.branch_target = '0; e.mem_addr = '0;
    e.mem_wdata = '0; e.wb_data = '0; e.wb_dst = '0;
    return e;
  endfunction

  function automatic exp_t idle_base();
    exp_t e = m;
    e.stall = 0; e.pc_src = 0; e.mem_req = 0; e.wb_valid = 0;
    return e;
  endfunction

  function automatic int fld(string nm, logic [DW-1:0] got, logic [DW-1:0] want);
    if (got !== want) begin
      $display("FAIL cyc_%s @%0t: got %h want %h", nm, $time, got, want);
      return 1;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      int bad;
      bad = 0;
      bad += fld("stall",        DW'(stall),        DW'(exp_cur.stall));
      bad += fld("pc_src",       DW'(pc_src),       DW'(exp_cur.pc_src));
      bad += fld("branch_tgt",   branch_target,     exp_cur.branch_target);
      bad += fld("mem_req",      DW'(mem_bus.req),  DW'(exp_cur.mem_req));
      bad += fld("wb_valid",     DW'(wb_valid),     DW'(exp_cur.wb_valid));
      bad += fld("wb_reg_write", DW'(wb_reg_write), DW'(exp_cur.wb_reg_write));
      bad += fld("wb_dst",       DW'(wb_dst),       DW'(exp_cur.wb_dst));
      bad += fld("wb_data",      wb_data,           exp_cur.wb_data);
      bad += fld("mem_err",      DW'(mem_err),      DW'(exp_cur.mem_err));
      if (exp_cur.mem_req) begin
        bad += fld("mem_we",    DW'(mem_bus.we),   DW'(exp_cur.mem_we));
        bad += fld("mem_addr",  mem_bus.addr,      exp_cur.mem_addr);
        bad += fld("mem_wdata", mem_bus.wdata,     exp_cur.mem_wdata);
      end
      n_cmp++;
      if (bad != 0) n_bad++;
    end
  end

  task automatic chk(string nm, logic [DW-1:0] got, logic [DW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  // Advance one edge; e is what the outputs must show afterwards.
  task automatic cycle(exp_t e);
    @(posedge clk);
    #1;
    exp_cur = e;
    m       = e;
    exp_on  = 1'b1;
  endtask

  task automatic set_in(logic v, logic [DW-1:0] alu, logic [DW-1:0] adder, logic z,
                        logic [DW-1:0] sd, logic [RW-1:0] dst, logic br, logic rd,
                        logic wr, logic rw, logic m2r);
    ex_valid = v; alu_result = alu; adder_result = adder; zero = z;
    store_data = sd; dst_reg = dst; ctl_branch = br; ctl_mem_read = rd;
    ctl_mem_write = wr; ctl_reg_write = rw; ctl_mem_to_reg = m2r;
  endtask

  task automatic junk();
    set_in(1'($urandom), DW'($urandom), DW'($urandom), 1'($urandom), DW'($urandom),
           RW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
  endtask

  task automatic alu_op(logic v, logic br, logic z, logic rw, logic [DW-1:0] alu,
                        logic [DW-1:0] adder, logic [RW-1:0] dst);
    exp_t e = idle_base();
    set_in(v, alu, adder, z, DW'($urandom), dst, br, 1'b0, 1'b0, rw, 1'($urandom));
    mem_bus.ack   = 1'($urandom);
    mem_bus.rdata = DW'($urandom);
    if (v) begin
      e.wb_valid = 1; e.wb_data = alu; e.wb_dst = dst; e.wb_reg_write = rw;
      e.pc_src = br & z; e.branch_target = adder;
    end
    cycle(e);
  endtask

  task automatic issue(logic rd, logic wr, logic rw, logic m2r, logic [DW-1:0] alu,
                       logic [DW-1:0] sd, logic [DW-1:0] adder, logic [RW-1:0] dst);
    exp_t e = idle_base();
    set_in(1'b1, alu, adder, 1'($urandom), sd, dst, 1'b0, rd, wr, rw, m2r);
    mem_bus.ack   = 1'($urandom);
    mem_bus.rdata = DW'($urandom);
    e.stall = 1; e.mem_req = 1; e.mem_we = wr; e.mem_addr = alu;
    e.mem_wdata = sd; e.branch_target = adder;
    cycle(e);
  endtask

  // Bench acts as the memory: acks on access cycle lat (lat > TO means never).
  task automatic mem_op(logic rd, logic wr, logic rw, logic m2r, logic [DW-1:0] alu,
                        logic [DW-1:0] sd, logic [DW-1:0] adder, logic [DW-1:0] rdata,
                        logic [RW-1:0] dst, int lat, output int req_cyc,
                        output logic first_we, output logic [DW-1:0] first_wdata);
    exp_t e;
    int   acc;
    issue(rd, wr, rw, m2r, alu, sd, adder, dst);
    req_cyc = 0;
    first_we = mem_bus.we;
    first_wdata = mem_bus.wdata;
    acc = (lat <= TO) ? lat : TO;
    for (int k = 1; k <= acc; k++) begin
      if (mem_bus.req === 1'b1 && stall === 1'b1) req_cyc++;
      junk();
      mem_bus.ack   = (k == lat);
      mem_bus.rdata = (k == lat) ? rdata : DW'($urandom);
      e = m;
      if (k == lat) begin
        e.stall = 0; e.mem_req = 0; e.wb_valid = 1; e.wb_dst = dst;
        e.wb_data = m2r ? rdata : alu; e.wb_reg_write = rw & ~wr;
      end else if (k == TO) begin
        e.stall = 0; e.mem_req = 0; e.wb_valid = 1; e.wb_dst = dst;
        e.wb_data = '0; e.wb_reg_write = 0; e.mem_err = 1;
      end
      cycle(e);
    end
    mem_bus.ack = 1'b0;
  endtask

  task automatic reset_mid();
    exp_t e;
    issue(1'b1, 1'b0, 1'b1, 1'b1, DW'($urandom), DW'($urandom), DW'($urandom), RW'($urandom));
    junk(); mem_bus.ack = 1'b0;
    cycle(m);
    rst = 1'b1; junk(); mem_bus.ack = 1'b0;
    cycle(zero_rec());
    chk("rstmid_stall", DW'(stall), '0);
    chk("rstmid_req", DW'(mem_bus.req), '0);
    chk("rstmid_wb_valid", DW'(wb_valid), '0);
    rst = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_bus.ack = 1'b1; mem_bus.rdata = DW'($urandom);
    e = idle_base();
    cycle(e);
    chk("late_ack_wb_valid", DW'(wb_valid), '0);
    chk("late_ack_err", DW'(mem_err), '0);
    mem_bus.ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            rc, lat;
    logic          fwe;
    logic [DW-1:0] fwd;
    rst = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    cycle(zero_rec());
    cycle(zero_rec());
    chk("reset_stall", DW'(stall), '0);
    chk("reset_req", DW'(mem_bus.req), '0);
    chk("reset_err", DW'(mem_err), '0);
    rst = 1'b0;

    alu_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 3'd5);
    chk("rtype_valid", DW'(wb_valid), 16'h1);
    chk("rtype_data", wb_data, 16'h1234);
    chk("rtype_dst", DW'(wb_dst), 16'd5);
    chk("rtype_stall", DW'(stall), '0);

    alu_op(1'b1, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0040, 3'd1);
    chk("br_taken", DW'(pc_src), 16'h1);
    chk("br_target", branch_target, 16'h0040);
    alu_op(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    chk("br_one_cycle", DW'(pc_src), '0);
    alu_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0080, 3'd1);
    chk("br_not_taken", DW'(pc_src), '0);

    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 3'd2, 3, rc, fwe, fwd);
    chk("load_req_cycles", DW'(rc), 16'd3);
    chk("load_data", wb_data, 16'hBEEF);
    chk("load_valid", DW'(wb_valid), 16'h1);

    mem_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0022, 16'h00AA, 16'h0000, 16'h0000, 3'd3, 1, rc, fwe, fwd);
    chk("store_req_cycles", DW'(rc), 16'd1);
    chk("store_we", DW'(fwe), 16'h1);
    chk("store_wdata", fwd, 16'h00AA);
    chk("store_valid", DW'(wb_valid), 16'h1);
    chk("store_regwrite", DW'(wb_reg_write), '0);

    mem_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 3'd4, TO + 5, rc, fwe, fwd);
    chk("to_req_cycles", DW'(rc), 16'd15);
    chk("to_err", DW'(mem_err), 16'h1);
    chk("to_regwrite", DW'(wb_reg_write), '0);
    chk("to_data", wb_data, '0);
    alu_op(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    alu_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000, 3'd6);
    chk("to_err_sticky", DW'(mem_err), 16'h1);

    reset_mid();

    for (int i = 0; i < 250; i++) begin
      int r;
      r   = int'($urandom_range(0, 99));
      lat = int'($urandom_range(1, 5));
      if ($urandom_range(0, 9) == 0) lat = TO + 3;
      else if ($urandom_range(0, 19) == 0) lat = TO;
      if (r < 15)
        alu_op(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), RW'($urandom));
      else if (r < 50)
        alu_op(1'b1, 1'b0, 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), RW'($urandom));
      else if (r < 65)
        alu_op(1'b1, 1'b1, 1'($urandom), 1'b0, DW'($urandom), DW'($urandom), RW'($urandom));
      else if (r < 80)
        mem_op(1'b1, 1'b0, 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom),
               DW'($urandom), DW'($urandom), RW'($urandom), lat, rc, fwe, fwd);
      else if (r < 93)
        mem_op(1'b0, 1'b1, 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom),
               DW'($urandom), DW'($urandom), RW'($urandom), lat, rc, fwe, fwd);
      else if (r < 97)
        mem_op(1'b1, 1'b1, 1'b1, 1'($urandom), DW'($urandom), DW'($urandom),
               DW'($urandom), DW'($urandom), RW'($urandom), lat, rc, fwe, fwd);
      else
        reset_mid();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage: registers the ALU result, branch target, Zero flag and destination register, and resolves branches (pc_src = Branch & Zero).
- Performs load/store through a req/ack handshake to an external data memory, and stalls the pipeline while an access is outstanding.
- Drives the MEM/WB register consumed by write-back.

Parameters:
- DATA_W, 16, data/address width
- REG_ADDR_W, 3, register-file index width
- TIMEOUT, 15, max cycles to wait for mem_ack before aborting (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a valid instruction this cycle
- alu_result  in  DATA_W  ALU result; memory address for load/store
- adder_result  in  DATA_W  branch target from execute
- zero  in  1  ALU Zero flag
- store_data  in  DATA_W  read_data_2 forwarded from execute
- dst_reg  in  REG_ADDR_W  rd/rt mux output
- ctl_branch, ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg  in  1 each  control bits
- stall  out  1  hold upstream stages (combinational from state)
- pc_src  out  1  take branch (registered)
- branch_target  out  DATA_W  registered adder_result
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- wb_valid  out  1  MEM/WB entry valid
- wb_reg_write  out  1  register-file write enable
- wb_dst  out  REG_ADDR_W  destination register
- wb_data  out  DATA_W  mem_rdata if ctl_mem_to_reg, else alu_result
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; all outputs 0, including stall, pc_src, mem_req and mem_err; timeout counter 0. Reset mid-access drops mem_req next cycle; a late mem_ack is ignored.
- States: IDLE, ACCESS.
- IDLE with ex_valid=1 and no memory op:
  - Next edge: wb_valid=1, wb_data=alu_result, wb_dst=dst_reg, wb_reg_write=ctl_reg_write.
  - pc_src=ctl_branch&zero; branch_target=adder_result.
  - Latency 1 cycle, no stall.
- IDLE with ex_valid=1 and ctl_mem_read or ctl_mem_write:
  - Latch address, wdata, dst and control; go to ACCESS.
  - mem_req=1, mem_we=ctl_mem_write, wb_valid=0, pc_src=0.
- ACCESS:
  - stall=1; mem_req, mem_we, mem_addr and mem_wdata held stable until ack.
  - On mem_ack: mem_req=0, return to IDLE. wb_valid=1 for one cycle; wb_data=mem_rdata for loads. A store gives wb_valid=1 with wb_reg_write=0.
  - A mem_ack in the same cycle the request is first raised is legal (minimum access 1 cycle in ACCESS).
- Timeout: the counter increments each ACCESS cycle without ack. On reaching TIMEOUT:
  - mem_req=0, go to IDLE, mem_err=1 (sticky until rst).
  - wb_valid=1 with wb_data=0 and wb_reg_write=0.
- ex_valid=0 in IDLE: wb_valid=0, pc_src=0; all other wb_* outputs hold their previous values.
- Inputs sampled while stall=1 are ignored; upstream must hold them.
- ctl_mem_read and ctl_mem_write both 1: treated as a write (mem_we=1) and wb_reg_write forced to 0.
- Branch outputs are registered every accepted instruction. A branch never accesses memory.
- All arithmetic is pass-through; no width changes. mem_ack in IDLE is ignored.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS) and the DATA_W/REG_ADDR_W defaults.
- One sub-module, mem_wb_reg: a MEM/WB pipeline register with synchronous reset and load enable, instanced for the wb_* outputs.
- FSM and timeout counter stay in the top.

Test Plan:
- R-type pass-through: ex_valid=1, alu_result=16'h1234, dst_reg=5, ctl_reg_write=1 -> next cycle wb_valid=1, wb_data=16'h1234, wb_dst=5, stall=0.
- Branch taken: ctl_branch=1, zero=1, adder_result=16'h0040 -> pc_src=1, branch_target=16'h0040 for one cycle. Repeat with zero=0 -> pc_src=0.
- Load with 3-cycle latency: ctl_mem_read=1, alu_result=16'h0010, mem_rdata=16'hBEEF acked on the 3rd ACCESS cycle -> mem_req=1 and stall=1 for 3 cycles; then wb_data=16'hBEEF and wb_valid=1.
- Store with immediate ack: ctl_mem_write=1, store_data=16'h00AA -> mem_we=1, mem_wdata=16'h00AA for 1 cycle; wb_valid=1 with wb_reg_write=0.
- Timeout: load with no mem_ack, TIMEOUT=15 -> mem_req drops after 15 cycles; mem_err=1 and stays 1; wb_reg_write=0.
- Reset mid-access: assert rst in cycle 2 of a load -> next cycle stall=0, mem_req=0, wb_valid=0; a following ack is ignored.
